// File: rtl/mul_job_sequencer_if.sv
// rtl/mul_job_sequencer_if.sv - operand/result streams, control and multiplier link of the job sequencer
interface mul_job_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_multiplier;
    logic [31:0]                  in_multiplicand;
    logic                         out_valid;
    logic                         out_ready;
    logic [63:0]                  out_result;
    logic                         abort;
    logic                         err;
    logic                         busy;
    logic [$clog2(DEPTH):0]       fifo_count;
    logic [31:0]                  m_multiplier;
    logic [31:0]                  m_multiplicand;
    logic                         m_op_start;
    logic                         m_op_clear;
    logic                         m_op_done;
    logic [63:0]                  m_result;

    modport slave (
        input  in_valid, in_multiplier, in_multiplicand, out_ready, abort, m_op_done, m_result,
        output in_ready, out_valid, out_result, err, busy, fifo_count,
               m_multiplier, m_multiplicand, m_op_start, m_op_clear
    );

    modport master (
        output in_valid, in_multiplier, in_multiplicand, out_ready, abort, m_op_done, m_result,
        input  in_ready, out_valid, out_result, err, busy, fifo_count,
               m_multiplier, m_multiplicand, m_op_start, m_op_clear
    );
endinterface

// File: rtl/mul_job_sequencer.sv
// rtl/mul_job_sequencer.sv - operand FIFO, multiplier job FSM with watchdog, and product output register
module mul_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 48
) (
    input  logic              clk,
    input  logic              reset,
    mul_job_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;

    state_t         state;
    logic [31:0]    mem_a [DEPTH];
    logic [31:0]    mem_b [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [WW-1:0]  wdog;
    logic           push;
    logic           pop;
    logic           capture;
    logic           timeout;

    assign bus.in_ready   = (count != CW'(DEPTH)) && !bus.abort;
    assign push           = bus.in_valid && bus.in_ready;
    assign capture        = (state == WAIT) && bus.m_op_done && (!bus.out_valid || bus.out_ready);
    assign timeout        = (state == WAIT) && !bus.m_op_done && (wdog == WW'(TIMEOUT - 1));
    assign pop            = capture || timeout;

    // The head stays put until the job ends, so the multiplier can reload it every INIT cycle.
    assign bus.m_multiplier   = mem_a[rd_ptr];
    assign bus.m_multiplicand = mem_b[rd_ptr];
    assign bus.fifo_count     = count;
    assign bus.busy           = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wdog           <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.err        <= 1'b0;
            bus.m_op_start <= 1'b0;
            bus.m_op_clear <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (bus.abort) begin
            state          <= CLEAR;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wdog           <= '0;
            bus.out_valid  <= 1'b0;
            bus.err        <= 1'b0;
            bus.m_op_start <= 1'b0;
            bus.m_op_clear <= 1'b1;
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= bus.in_multiplier;
                mem_b[wr_ptr] <= bus.in_multiplicand;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A capture in the same cycle as a consume keeps out_valid high with fresh data.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (capture) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= bus.m_result;
            end
            if (timeout) begin
                bus.err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.m_op_start <= 1'b0;
                    bus.m_op_clear <= 1'b0;
                    if (count != '0) begin
                        state          <= ISSUE;
                        bus.m_op_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    bus.m_op_start <= 1'b0;
                    wdog           <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (pop) begin
                        state          <= CLEAR;
                        bus.m_op_clear <= 1'b1;
                    end else if (!bus.m_op_done) begin
                        wdog <= wdog + WW'(1);
                    end
                end
                CLEAR: begin
                    bus.m_op_clear <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
